hc148_event_fifo: RTL and testbench
===================================

Name: hc148_event_fifo

Overview:
- Downstream consumer of the 8-to-3 priority encoder; accepts its active-low outputs GS and dout[2:0].
- Synchronises and filters the encoder outputs, then turns each new stable priority code into one event.
- Buffers the events in a small FIFO and presents them on a valid/ready interface to the display/control logic.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
STABLE_CYCLES, 3, consecutive cycles a synchronised sample must hold before it is accepted; 1..15.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
gs_n  input  1  encoder GS, active-low (0 = some input active); asynchronous to clk.
code_n  input  3  encoder dout, active-low code; asynchronous to clk.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts head entry when high with out_valid.
out_code  output  3  head entry, true binary (bitwise inverse of code_n).
count  output  clog2(DEPTH)+1  current occupancy.
overflow  output  1  sticky flag: an event was dropped.
clr_ovf  input  1  clears overflow (synchronous).

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst). While rst=1 at an edge: synchroniser flops <= gs_n=1, code_n=3'b111; candidate = inactive/000; stability counter = 0; accepted = inactive/000; FIFO flushed; out_valid=0, out_code=000, count=0, overflow=0. Reset mid-operation discards all queued and pending events.
- Synchroniser: two flops on {gs_n, code_n}. Treat the 4 bits as one word. Multi-bit skew is absorbed by the stability filter.
- Sample decode: active = ~gs_n_sync; code = ~code_n_sync. When active=0, code is forced to 000.
- Stability filter:
  - If {active,code} != candidate: candidate <= sample, cnt <= 1.
  - Else if cnt < STABLE_CYCLES: cnt <= cnt+1.
  - If cnt == STABLE_CYCLES and candidate != accepted: accepted <= candidate.
- Event generation, on an accepted update:
  - Push candidate code when the new accepted value is active and either the previous accepted value was inactive or the code differs.
  - Transition to inactive: no push.
  - Repeated identical active code with no intervening inactive period: no push.
- Latency: new value first sampled at edge 1 -> out_valid high after edge STABLE_CYCLES+3 (edge 6 at default), provided the FIFO was empty.
- Glitch rejection: any value held fewer than STABLE_CYCLES synchronised cycles produces no event.
- FIFO: show-ahead; out_code = head whenever out_valid=1; out_code is 000 when empty.
  - Pop when out_valid & out_ready.
  - Push when event & (not full | pop same cycle).
  - Full + pop + push in the same cycle: both occur; count unchanged.
  - Empty + push: out_valid rises the next cycle. There is no same-cycle bypass.
  - out_ready while empty: ignored.
  - Pointers wrap modulo DEPTH.
- Overflow: event while full and no pop -> event dropped, overflow <= 1. Stays set until clr_ovf=1 or rst. If clr_ovf and a new drop coincide, the drop wins (overflow stays 1).
- count: always equals pushes minus pops since reset; range 0..DEPTH.

Optional Feature:
HC148_EVT_TIMESTAMP_EN
- Defined: adds a 16-bit free-running cycle counter (reset to 0, wraps 0xFFFF->0). Each FIFO entry stores the counter value at the push edge. Adds output out_ts[15:0], which is the head timestamp when out_valid=1 and 0 when empty.
- Undefined: no counter and no timestamp storage; out_ts is present and tied to 16'h0000.

Test Plan:
- Reset, then gs_n=1, code_n=111 for 20 cycles -> out_valid=0, count=0, overflow=0 throughout.
- gs_n=0, code_n=010 held, out_ready=0 -> out_valid=1 after edge 6, out_code=101, count=1. Holding for 50 more cycles -> count stays 1.
- code_n pulses to 100 for 2 cycles, otherwise inactive (STABLE_CYCLES=3) -> no event, count=0.
- Stable codes 7,3,7 each held 10 cycles, then inactive, then 7 again; out_ready=1 -> out_code sequence 7,3,7,7. Inactive periods produce nothing.
- out_ready=0; 5 distinct stable codes 1..5 (DEPTH=4) -> count=4, overflow=1, queue holds 1,2,3,4. Then clr_ovf pulse -> overflow=0. Draining yields 1,2,3,4.
- FIFO full, a new event pushed in the same cycle as a pop -> count stays 4, no overflow. Assert rst mid-stream -> next cycle out_valid=0, count=0.

Source files
------------

// File: rtl/hc148_event_fifo_if.sv
// Event FIFO bundle: encoder inputs, valid/ready head port and status.
// master = event FIFO side, slave = encoder/consumer side.
interface hc148_event_fifo_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          gs_n;
    logic [2:0]    code_n;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_code;
    logic [CW-1:0] count;
    logic          overflow;
    logic          clr_ovf;
    logic [15:0]   out_ts;

    modport master (
        input  gs_n, code_n, out_ready, clr_ovf,
        output out_valid, out_code, count, overflow, out_ts
    );

    modport slave (
        output gs_n, code_n, out_ready, clr_ovf,
        input  out_valid, out_code, count, overflow, out_ts
    );
endinterface

// File: rtl/hc148_event_fifo.sv
// Synchronises/debounces 74HC148 outputs and queues one event per new code.
// Optional HC148_EVT_TIMESTAMP_EN adds a 16-bit push timestamp per entry.
module hc148_event_fifo #(
    parameter int DEPTH         = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    hc148_event_fifo_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0]    STAB  = 4'(STABLE_CYCLES);
    localparam logic [CW-1:0] FULLN = CW'(DEPTH);

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_cand;
    logic [3:0]    r_cnt;
    logic [3:0]    r_acc;
    logic [2:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic [3:0] w_sample;
    logic       w_accept;
    logic       w_event;
    logic       w_full;
    logic       w_valid;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;

    // Sample word is {active, code}; inactive always reads as 4'h0.
    assign w_sample = r_sync2[3] ? 4'h0 : {1'b1, ~r_sync2[2:0]};
    assign w_accept = (r_cnt == STAB) && (r_cand != r_acc);
    assign w_event  = w_accept && r_cand[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
            r_cand  <= 4'h0;
            r_cnt   <= 4'h0;
            r_acc   <= 4'h0;
        end else begin
            r_sync1 <= {bus.gs_n, bus.code_n};
            r_sync2 <= r_sync1;
            if (w_sample != r_cand) begin
                r_cand <= w_sample;
                r_cnt  <= 4'h1;
            end else if (r_cnt < STAB) begin
                r_cnt <= r_cnt + 4'h1;
            end
            if (w_accept) begin
                r_acc <= r_cand;
            end
        end
    end

    assign w_full  = (r_count == FULLN);
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & bus.out_ready;
    assign w_push  = w_event & (~w_full | w_pop);
    assign w_drop  = w_event & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_cand[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.out_valid = w_valid;
    assign bus.out_code  = w_valid ? r_mem[r_rptr] : 3'b000;
    assign bus.count     = r_count;
    assign bus.overflow  = r_ovf;

`ifdef HC148_EVT_TIMESTAMP_EN
    logic [15:0] r_ts;
    logic [15:0] r_ts_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts <= 16'h0000;
        end else begin
            r_ts <= r_ts + 16'h0001;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ts_mem[r_wptr] <= r_ts;
        end
    end

    assign bus.out_ts = w_valid ? r_ts_mem[r_rptr] : 16'h0000;
`else
    assign bus.out_ts = 16'h0000;
`endif
endmodule

// File: tb/tb_hc148_event_fifo.sv
// Randomised bench for hc148_event_fifo against a history-window model.
// The model decides acceptance from the raw input history and a code queue.
module tb_hc148_event_fifo;
    localparam int DEPTH = 4;
    localparam int S     = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hc148_event_fifo_if #(.DEPTH(DEPTH)) bus ();

    hc148_event_fifo #(
        .DEPTH(DEPTH),
        .STABLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int hist[$];
    int mq_code[$];
    int mq_ts[$];
    int macc;
    int mts;
    bit movf;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < S + 3; k++) hist.push_back(0);
        mq_code.delete();
        mq_ts.delete();
        macc = 0;
        mts  = 0;
        movf = 1'b0;
    endtask

    // Input seen at edge e reaches the filter's decision at edge e+3.
    task automatic model_edge(input bit g, input logic [2:0] c,
                              input bit rdy, input bit clr);
        int  w;
        int  x;
        int  n;
        bit  same;
        bit  ev;
        bit  pop;
        bit  drop;
        w = g ? 0 : (8 | (~int'(c) & 7));
        hist.push_back(w);
        n = hist.size();
        x = hist[n - 4];
        same = 1'b1;
        for (int k = 3; k <= S + 2; k++) begin
            if (hist[n - 1 - k] != x) same = 1'b0;
        end
        ev = same && (x != macc);
        if (ev) macc = x;
        ev = ev && ((x & 8) != 0);
        pop = rdy && (mq_code.size() > 0);
        drop = 1'b0;
        if (pop) begin
            void'(mq_code.pop_front());
            void'(mq_ts.pop_front());
        end
        if (ev) begin
            if (mq_code.size() < DEPTH) begin
                mq_code.push_back(x & 7);
                mq_ts.push_back(mts);
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) movf = 1'b1;
        else if (clr) movf = 1'b0;
        mts = (mts + 1) & 16'hFFFF;
        if (hist.size() > 40) void'(hist.pop_front());
    endtask

    task automatic compare();
        bit emp;
        int ets;
        emp = (mq_code.size() == 0);
`ifdef HC148_EVT_TIMESTAMP_EN
        ets = emp ? 0 : mq_ts[0];
`else
        ets = 0;
`endif
        chk("valid", 32'(bus.out_valid), emp ? 0 : 1);
        chk("code", 32'(bus.out_code), emp ? 0 : mq_code[0]);
        chk("count", 32'(bus.count), mq_code.size());
        chk("ovf", 32'(bus.overflow), 32'(movf));
        chk("ts", 32'(bus.out_ts), ets);
    endtask

    task automatic step(input bit g, input logic [2:0] c, input bit rdy,
                        input bit clr, input bit r);
        @(negedge clk);
        bus.gs_n      = g;
        bus.code_n    = c;
        bus.out_ready = rdy;
        bus.clr_ovf   = clr;
        rst           = r;
        @(posedge clk);
        if (r) model_reset();
        else model_edge(g, c, rdy, clr);
        #1;
        compare();
    endtask

    task automatic hold(input int code, input int len, input bit rdy);
        logic [2:0] cn;
        cn = ~3'(code);
        for (int k = 0; k < len; k++) step(1'b0, cn, rdy, 1'b0, 1'b0);
    endtask

    task automatic idle(input int len, input bit rdy);
        for (int k = 0; k < len; k++) step(1'b1, 3'b111, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        bus.gs_n      = 1'b1;
        bus.code_n    = 3'b111;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        rst           = 1'b1;
        model_reset();
        step(1'b1, 3'b111, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'b111, 1'b0, 1'b0, 1'b1);

        idle(20, 1'b0);
        chk("idle_cnt", 32'(bus.count), 0);

        hold(5, 5, 1'b0);
        chk("lat5_valid", 32'(bus.out_valid), 0);
        hold(5, 1, 1'b0);
        chk("lat6_valid", 32'(bus.out_valid), 1);
        chk("lat6_code", 32'(bus.out_code), 5);
        hold(5, 50, 1'b0);
        chk("hold_cnt", 32'(bus.count), 1);
        idle(10, 1'b1);

        step(1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
        idle(10, 1'b0);
        chk("glitch_cnt", 32'(bus.count), 0);

        hold(7, 10, 1'b1);
        hold(3, 10, 1'b1);
        hold(7, 10, 1'b1);
        idle(10, 1'b1);
        hold(7, 10, 1'b1);
        idle(10, 1'b1);

        for (int v = 1; v <= 5; v++) hold(v, 6, 1'b0);
        chk("ovf_cnt", 32'(bus.count), DEPTH);
        chk("ovf_flag", 32'(bus.overflow), 1);
        step(1'b0, ~3'd5, 1'b0, 1'b1, 1'b0);
        chk("ovf_clr", 32'(bus.overflow), 0);
        idle(8, 1'b1);

        for (int v = 1; v <= 4; v++) hold(v, 6, 1'b0);
        hold(6, 5, 1'b0);
        hold(6, 1, 1'b1);
        chk("fullpp_cnt", 32'(bus.count), DEPTH);
        chk("fullpp_ovf", 32'(bus.overflow), 0);
        hold(6, 3, 1'b0);
        step(1'b0, ~3'd6, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_cnt", 32'(bus.count), 0);

        for (int seg = 0; seg < 1500; seg++) begin
            bit         g;
            logic [2:0] c;
            int         len;
            int         rb;
            g   = ($urandom_range(3, 0) == 0);
            c   = 3'($urandom_range(7, 0));
            len = $urandom_range(10, 1);
            rb  = ((seg / 100) % 2 == 0) ? 2 : 8;
            for (int k = 0; k < len; k++) begin
                step(g, c, ($urandom_range(9, 0) < rb),
                     ($urandom_range(19, 0) == 0),
                     ($urandom_range(399, 0) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
